// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage - EX->MEM pipeline register with N/Z/V flag register and branch condition evaluation.
// Optional feature macro: EX_FLAG_BYPASS_EN (branch evaluation sees this cycle's flag update).
module ex_mem_flag_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_ovfl,
    input  logic [DATA_W-1:0] ex_store_dat,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_mem_re,
    input  logic              ex_mem_we,
    input  logic              stall,
    input  logic              flush,
    input  logic [2:0]        br_ccc,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_dat,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_we,
    output logic              mem_mem_re,
    output logic              mem_mem_we,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_v,
    output logic              br_taken
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic              valid_q, reg_we_q, mem_re_q, mem_we_q;
    logic [DATA_W-1:0] result_q, store_dat_q;
    logic [REG_AW-1:0] rd_q;
    logic              n_q, z_q, v_q;
    logic              n_d, z_d, v_d;
    logic              fire;
    logic              bn, bz, bv;

    assign fire = ex_valid & ~stall & ~flush;

    always_comb begin
        n_d = n_q;
        z_d = z_q;
        v_d = v_q;
        if (fire) begin
            unique case (ex_opcode)
                OP_ADD, OP_SUB: begin
                    n_d = ex_result[DATA_W-1];
                    z_d = (ex_result == '0);
                    v_d = ex_ovfl;
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: z_d = (ex_result == '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            result_q    <= '0;
            store_dat_q <= '0;
            rd_q        <= '0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            v_q         <= 1'b0;
        end else if (!stall) begin
            valid_q  <= ex_valid & ~flush;
            reg_we_q <= ex_reg_we & ~flush;
            mem_re_q <= ex_mem_re & ~flush;
            mem_we_q <= ex_mem_we & ~flush;
            // A flushed bubble leaves the data fields untouched.
            if (!flush) begin
                result_q    <= ex_result;
                store_dat_q <= ex_store_dat;
                rd_q        <= ex_rd;
            end
            n_q <= n_d;
            z_q <= z_d;
            v_q <= v_d;
        end
    end

`ifdef EX_FLAG_BYPASS_EN
    assign bn = n_d;
    assign bz = z_d;
    assign bv = v_d;
`else
    assign bn = n_q;
    assign bz = z_q;
    assign bv = v_q;
`endif

    always_comb begin
        br_taken = 1'b0;
        unique case (br_ccc)
            3'b000: br_taken = ~bz;
            3'b001: br_taken = bz;
            3'b010: br_taken = ~bz & ~bn;
            3'b011: br_taken = bn;
            3'b100: br_taken = bz | (~bz & ~bn);
            3'b101: br_taken = bn | bz;
            3'b110: br_taken = bv;
            3'b111: br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    assign mem_valid     = valid_q;
    assign mem_result    = result_q;
    assign mem_store_dat = store_dat_q;
    assign mem_rd        = rd_q;
    assign mem_reg_we    = reg_we_q;
    assign mem_mem_re    = mem_re_q;
    assign mem_mem_we    = mem_we_q;
    assign flag_n        = n_q;
    assign flag_z        = z_q;
    assign flag_v        = v_q;

endmodule
